dac_update_scheduler: RTL and testbench
=======================================

Name: dac_update_scheduler

Overview:
- Sequences the dual-channel serial DAC link of the sine-wave generator.
- Generates the sample-rate tick from a programmable divider.
- On each tick, arbitrates the shared serial link between channel A and channel B sample sources in fixed order A then B. It serialises one 16-bit frame per granted channel, then pulses the load strobe so both DAC outputs update together.
- Sits between the sine sample generators and the DAC pins.

Parameters:
- TICK_DIV, 1000: clk cycles per sample tick (≥ 2).
- SCLK_DIV, 2: clk cycles per SCLK half-period (≥ 1).
- DATA_WIDTH, 12: sample width; frame is always 16 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = tick divider runs.
- a_valid  in  1  channel A sample available.
- a_data  in  DATA_WIDTH  channel A sample.
- a_ready  out  1  one-cycle pulse: A sample accepted.
- b_valid  in  1  channel B sample available.
- b_data  in  DATA_WIDTH  channel B sample.
- b_ready  out  1  one-cycle pulse: B sample accepted.
- cs_n  out  1  DAC chip select, active low.
- sclk  out  1  DAC serial clock, idle low.
- sdi  out  1  DAC serial data, MSB first.
- ldac_n  out  1  DAC load strobe, active low.
- tick  out  1  one-cycle sample tick.
- busy  out  1  1 when FSM is not IDLE.
- overrun  out  1  one-cycle pulse: tick arrived while busy.

Behaviour:
- Reset (async, rst_n=0) forces the following; any partial frame is abandoned and no ldac pulse is issued.
  - Outputs: cs_n=1, sclk=0, sdi=0, ldac_n=1, a_ready=0, b_ready=0, tick=0, busy=0, overrun=0.
  - Internal: tick counter=0, state=IDLE, sent flag=0.
- All outputs are registered, with no combinational input→output paths.
- Tick counter:
  - While enable=1, counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1.
  - While enable=0, the counter is held at 0 and tick=0.
- Frame format, bit15..0: {ch, 1'b0 (BUF), 1'b1 (GA_n), 1'b1 (SHDN_n), data[11:0]}, where ch=0 for A and 1 for B.
- FSM states:
  - IDLE: on tick → CHK_A and clear the sent flag.
  - CHK_A (1 cycle):
    - If a_valid: a_ready=1 this cycle, capture a_data, set the sent flag, record current channel = A, → SETUP.
    - Otherwise → CHK_B (channel A is skipped and keeps its old DAC value).
  - SETUP (1 cycle): cs_n=0, sclk=0, sdi=frame[15] → SHIFT.
  - SHIFT:
    - Each bit lasts 2·SCLK_DIV cycles: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
    - sdi is stable for the whole bit and changes only with the sclk falling edge.
    - After the high phase of bit 0, → GAP with sclk=0.
    - cs_n stays low for 1 + 32·SCLK_DIV cycles per frame.
  - GAP (2 cycles): cs_n=1, sclk=0. Then → CHK_B if the current channel was A, otherwise → LOAD.
  - CHK_B: same as CHK_A for channel B. If b_valid=0 → LOAD.
  - LOAD:
    - If the sent flag is set: ldac_n=0 for exactly 2 cycles, then → IDLE.
    - Otherwise → IDLE in 1 cycle with ldac_n held at 1.
- Overrun:
  - A tick while state≠IDLE is dropped and overrun pulses 1 cycle.
  - The current sequence continues unaffected.
- Deasserting enable mid-sequence: the sequence completes, including LOAD; no new tick follows.
- Handshakes:
  - Sources must hold data stable while valid=1.
  - valid may drop without a ready; there is no penalty.
  - A channel is granted at most once per tick.
- Full A+B sequence at SCLK_DIV=2 is 138 cycles from the tick to IDLE.

Test Plan:
1. Reset, then enable=1 with TICK_DIV=200 and a_valid=b_valid=1 held → tick every 200 cycles; in each sequence:
   - a_ready pulses, then cs_n low for 65 cycles shifting 0x3ABC for a_data=0xABC;
   - 2 cycles of gap, then b_ready pulses and frame 0xB123 is shifted for b_data=0x123;
   - ldac_n low for 2 cycles; busy high for 138 cycles.
2. a_valid=0, b_valid=1 → a_ready stays 0, a single frame with bit15=1 is sent, followed by the ldac pulse. With both valids=0 → no cs_n activity and ldac_n stays 1.
3. TICK_DIV=100 with both channels valid → overrun pulses once per sequence, ticks are dropped, and frames are intact.
4. rst_n asserted during bit 7 of frame A → cs_n=1, sclk=0, ldac_n=1 immediately. After release, nothing is sent until the next full tick period.
5. enable deasserted in the B frame → B frame and ldac complete; no further tick. Re-enable → first tick after TICK_DIV cycles.
6. SCLK_DIV=1 → sclk period is 2 cycles, cs_n low for 33 cycles, and the sdi sampled on sclk rising edges reproduces the frame.

Source files
------------

// File: rtl/dac_update_scheduler.sv
// Dual-channel serial DAC link sequencer: divides clk down to a sample tick,
// then sends one 16-bit frame for channel A and one for channel B (each only
// if a sample is offered) and finishes with a shared ldac_n strobe so both
// DAC outputs update together.
module dac_update_scheduler #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  sdi,
    output logic                  ldac_n,
    output logic                  tick,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned PW = $clog2(2 * SCLK_DIV);
    localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PhaseLast = PW'(2 * SCLK_DIV - 1);
    // Last low-phase count; the next bit cycle is the first with sclk high.
    localparam logic [PW-1:0] PhaseRise = PW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_A, CHK_B, SETUP, SHIFT, GAP, LOAD
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [TW-1:0]   tick_cnt_d;
    logic            tick_d;
    logic [15:0]     frame;
    logic [3:0]      bit_idx;
    logic [PW-1:0]   phase;
    logic            step;      // second cycle of GAP / LOAD
    logic            sent;      // a frame went out since the last tick
    logic            cur_b;     // frame in flight belongs to channel B

    // Frame layout: channel select, BUF=0, GA_n=1, SHDN_n=1, 12-bit code.
    function automatic logic [15:0] make_frame(input logic ch,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [11:0] code;
        code = 12'(d);
        return {ch, 3'b011, code};
    endfunction

    // Next tick-counter value; tick is registered so it lines up with TICK_DIV-1.
    always_comb begin
        tick_cnt_d = '0;
        if (enable && (tick_cnt != TickLast)) begin
            tick_cnt_d = tick_cnt + TW'(1);
        end
        tick_d = enable && (tick_cnt_d == TickLast);
    end

    // Tick divider, sequencing FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
            state    <= IDLE;
            frame    <= '0;
            bit_idx  <= '0;
            phase    <= '0;
            step     <= 1'b0;
            sent     <= 1'b0;
            cur_b    <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            sdi      <= 1'b0;
            ldac_n   <= 1'b1;
            a_ready  <= 1'b0;
            b_ready  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_d;
            tick     <= tick_d;
            a_ready  <= 1'b0;
            b_ready  <= 1'b0;
            // A tick seen outside IDLE is simply dropped.
            overrun  <= tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= CHK_A;
                        sent  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                CHK_A: begin
                    if (a_valid) begin
                        a_ready <= 1'b1;
                        frame   <= make_frame(1'b0, a_data);
                        sent    <= 1'b1;
                        cur_b   <= 1'b0;
                        cs_n    <= 1'b0;
                        sdi     <= 1'b0;
                        state   <= SETUP;
                    end else begin
                        state <= CHK_B;
                    end
                end
                CHK_B: begin
                    if (b_valid) begin
                        b_ready <= 1'b1;
                        frame   <= make_frame(1'b1, b_data);
                        sent    <= 1'b1;
                        cur_b   <= 1'b1;
                        cs_n    <= 1'b0;
                        sdi     <= 1'b1;
                        state   <= SETUP;
                    end else begin
                        ldac_n <= ~sent;
                        step   <= 1'b0;
                        state  <= LOAD;
                    end
                end
                SETUP: begin
                    bit_idx <= 4'd15;
                    phase   <= '0;
                    sclk    <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (phase == PhaseLast) begin
                        // End of a bit: falling sclk edge carries the next bit.
                        sclk  <= 1'b0;
                        phase <= '0;
                        if (bit_idx == 4'd0) begin
                            cs_n  <= 1'b1;
                            sdi   <= 1'b0;
                            step  <= 1'b0;
                            state <= GAP;
                        end else begin
                            bit_idx <= bit_idx - 4'd1;
                            sdi     <= frame[bit_idx - 4'd1];
                        end
                    end else begin
                        phase <= phase + PW'(1);
                        sclk  <= (phase >= PhaseRise);
                    end
                end
                GAP: begin
                    if (step) begin
                        step <= 1'b0;
                        if (cur_b) begin
                            ldac_n <= ~sent;
                            state  <= LOAD;
                        end else begin
                            state <= CHK_B;
                        end
                    end else begin
                        step <= 1'b1;
                    end
                end
                LOAD: begin
                    if (sent && !step) begin
                        step <= 1'b1;
                    end else begin
                        step   <= 1'b0;
                        ldac_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler. Three instances share stimulus:
// g[0] TICK_DIV=200/SCLK_DIV=2, g[1] TICK_DIV=100/SCLK_DIV=2 (overrun case),
// g[2] TICK_DIV=200/SCLK_DIV=1. A per-instance monitor decodes the serial
// link and tallies strobes; directed tables give the expected results.
module tb_dac_update_scheduler;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [11:0] a_data = '0;
    logic [11:0] b_data = '0;
    logic        mon_clr = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    wire [NI-1:0] cs_n, sclk, sdi, ldac_n, a_ready, b_ready, tick, busy, overrun;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g
        dac_update_scheduler #(
            .TICK_DIV  (gi == 1 ? 100 : 200),
            .SCLK_DIV  (gi == 2 ? 1 : 2),
            .DATA_WIDTH(12)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .a_valid(a_valid),
            .a_data (a_data),
            .a_ready(a_ready[gi]),
            .b_valid(b_valid),
            .b_data (b_data),
            .b_ready(b_ready[gi]),
            .cs_n   (cs_n[gi]),
            .sclk   (sclk[gi]),
            .sdi    (sdi[gi]),
            .ldac_n (ldac_n[gi]),
            .tick   (tick[gi]),
            .busy   (busy[gi]),
            .overrun(overrun[gi])
        );

        logic [15:0] sh, frm0, frm1;
        logic        cs_p, sclk_p, sdi_p, ldac_p, busy_p;
        int nfrm, len0, low_len, cs_low_tot, ar, br, ovr, ntick, last_tick, tick_gap;
        int ldac_runs, ldac_len, ldac_cur, busy_runs, busy_len, busy_cur, sdi_bad, sclk_bad;

        // Link monitor, sampled mid-cycle.
        always @(negedge clk) begin
            if (mon_clr) begin
                sh <= '0; frm0 <= '0; frm1 <= '0;
                cs_p <= 1'b1; sclk_p <= 1'b0; sdi_p <= 1'b0; ldac_p <= 1'b1; busy_p <= 1'b0;
                nfrm <= 0; len0 <= 0; low_len <= 0; cs_low_tot <= 0; ar <= 0; br <= 0;
                ovr <= 0; ntick <= 0; last_tick <= 0; tick_gap <= 0;
                ldac_runs <= 0; ldac_len <= 0; ldac_cur <= 0;
                busy_runs <= 0; busy_len <= 0; busy_cur <= 0; sdi_bad <= 0; sclk_bad <= 0;
            end else begin
                cs_p <= cs_n[gi]; sclk_p <= sclk[gi]; sdi_p <= sdi[gi];
                ldac_p <= ldac_n[gi]; busy_p <= busy[gi];
                if (!cs_n[gi]) begin
                    low_len <= low_len + 1;
                    cs_low_tot <= cs_low_tot + 1;
                    if (sclk[gi] && !sclk_p) sh <= {sh[14:0], sdi[gi]};
                    // sdi may only move on a falling sclk edge inside the frame
                    if (sdi[gi] != sdi_p && !cs_p && !(sclk_p && !sclk[gi]))
                        sdi_bad <= sdi_bad + 1;
                end
                if (cs_n[gi] && sclk[gi]) sclk_bad <= sclk_bad + 1;
                if (cs_n[gi] && !cs_p) begin
                    if (nfrm == 0) begin
                        frm0 <= sh;
                        len0 <= low_len;
                    end else if (nfrm == 1) begin
                        frm1 <= sh;
                    end
                    nfrm <= nfrm + 1;
                    low_len <= 0;
                end
                if (!ldac_n[gi]) ldac_cur <= ldac_cur + 1;
                if (ldac_n[gi] && !ldac_p) begin
                    ldac_runs <= ldac_runs + 1;
                    ldac_len <= ldac_cur;
                    ldac_cur <= 0;
                end
                if (busy[gi]) busy_cur <= busy_cur + 1;
                if (!busy[gi] && busy_p) begin
                    busy_runs <= busy_runs + 1;
                    busy_len <= busy_cur;
                    busy_cur <= 0;
                end
                ar <= ar + int'(a_ready[gi]);
                br <= br + int'(b_ready[gi]);
                ovr <= ovr + int'(overrun[gi]);
                if (tick[gi]) begin
                    ntick <= ntick + 1;
                    tick_gap <= cyc - last_tick;
                    last_tick <= cyc;
                end
            end
        end
    end

    typedef struct {
        logic        av, bv;
        logic [11:0] ad, bd;
        int          nfrm0;
        logic [15:0] f0, f1;
        int          busy0, busy2, seq1, ovr1;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reset all instances and clear monitors; leaves enable low.
    task automatic restart();
        rst_n = 1'b0;
        enable = 1'b0;
        mon_clr = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(1);
        mon_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0] = '{1'b1, 1'b1, 12'hABC, 12'h123, 4, 16'h3ABC, 16'hB123, 138, 74, 2, 2};
        vt[1] = '{1'b0, 1'b1, 12'hABC, 12'h123, 2, 16'hB123, 16'hB123, 71, 39, 4, 0};
        vt[2] = '{1'b0, 1'b0, 12'hABC, 12'h123, 0, 16'h0000, 16'h0000, 3, 3, 4, 0};
        vt[3] = '{1'b1, 1'b0, 12'h5A5, 12'hFFF, 2, 16'h35A5, 16'h35A5, 71, 39, 4, 0};
        vt[4] = '{1'b1, 1'b1, 12'h000, 12'hFFF, 4, 16'h3000, 16'hBFFF, 138, 74, 2, 2};

        step(3);
        chk("reset_outputs", int'({cs_n, sclk, sdi, ldac_n, a_ready, b_ready, tick, busy, overrun}),
            int'({{NI{1'b1}}, {NI{1'b0}}, {NI{1'b0}}, {NI{1'b1}}, {5 * NI{1'b0}}}));

        // Table: two tick periods of g[0] with enable high, then drain.
        for (int i = 0; i < 5; i++) begin
            restart();
            a_valid = vt[i].av; b_valid = vt[i].bv;
            a_data = vt[i].ad; b_data = vt[i].bd;
            enable = 1'b1;
            step(450);
            enable = 1'b0;
            step(250);
            chk($sformatf("v%0d_nfrm", i), g[0].nfrm, vt[i].nfrm0);
            chk($sformatf("v%0d_frame0", i), g[0].frm0, vt[i].f0);
            chk($sformatf("v%0d_frame1", i), g[0].frm1, vt[i].f1);
            if (vt[i].nfrm0 > 0) begin
                chk($sformatf("v%0d_cs_low", i), g[0].len0, 65);
                chk($sformatf("v%0d_ldac_len", i), g[0].ldac_len, 2);
                chk($sformatf("v%0d_cs_low_div1", i), g[2].len0, 33);
            end
            chk($sformatf("v%0d_ldac_runs", i), g[0].ldac_runs, vt[i].nfrm0 > 0 ? 2 : 0);
            chk($sformatf("v%0d_busy_len", i), g[0].busy_len, vt[i].busy0);
            chk($sformatf("v%0d_busy_runs", i), g[0].busy_runs, 2);
            chk($sformatf("v%0d_a_ready", i), g[0].ar, vt[i].av ? 2 : 0);
            chk($sformatf("v%0d_b_ready", i), g[0].br, vt[i].bv ? 2 : 0);
            chk($sformatf("v%0d_ticks", i), g[0].ntick, 2);
            chk($sformatf("v%0d_tick_period", i), g[0].tick_gap, 200);
            chk($sformatf("v%0d_sdi_stable", i), g[0].sdi_bad + g[2].sdi_bad, 0);
            chk($sformatf("v%0d_sclk_idle", i), g[0].sclk_bad + g[2].sclk_bad, 0);
            chk($sformatf("v%0d_ovr_none", i), g[0].ovr, 0);
            chk($sformatf("v%0d_seq_td100", i), g[1].busy_runs, vt[i].seq1);
            chk($sformatf("v%0d_ovr_td100", i), g[1].ovr, vt[i].ovr1);
            chk($sformatf("v%0d_frame0_td100", i), g[1].frm0, vt[i].f0);
            chk($sformatf("v%0d_frame1_td100", i), g[1].frm1, vt[i].f1);
            chk($sformatf("v%0d_busy_div1", i), g[2].busy_len, vt[i].busy2);
            chk($sformatf("v%0d_frame0_div1", i), g[2].frm0, vt[i].f0);
            chk($sformatf("v%0d_frame1_div1", i), g[2].frm1, vt[i].f1);
        end

        // Reset in the middle of bit 7 of frame A.
        restart();
        a_valid = 1'b1; b_valid = 1'b1; a_data = 12'hABC; b_data = 12'h123;
        enable = 1'b1;
        n = 0;
        while (cs_n[0] && n < 400) begin
            step(1);
            n++;
        end
        chk("rst_frame_started", int'(cs_n[0]), 0);
        step(34);
        chk("rst_mid_frame", int'({cs_n[0], busy[0]}), 32'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'({cs_n[0], sclk[0], sdi[0], ldac_n[0], busy[0]}), 32'b10010);
        step(1);
        rst_n = 1'b1;
        mon_clr = 1'b1;
        step(1);
        mon_clr = 1'b0;
        step(190);
        chk("rst_quiet_ticks", g[0].ntick, 0);
        chk("rst_quiet_cs", g[0].cs_low_tot, 0);
        chk("rst_quiet_ldac", g[0].ldac_runs, 0);
        step(20);
        chk("rst_next_tick", g[0].ntick, 1);

        // Drop enable during frame B; the sequence still completes.
        restart();
        enable = 1'b1;
        n = 0;
        while (!b_ready[0] && n < 400) begin
            step(1);
            n++;
        end
        chk("en_b_granted", int'(b_ready[0]), 1);
        step(10);
        enable = 1'b0;
        step(300);
        chk("en_frames", g[0].nfrm, 2);
        chk("en_frame_b", g[0].frm1, 16'hB123);
        chk("en_ldac", g[0].ldac_runs, 1);
        chk("en_one_tick", g[0].ntick, 1);
        chk("en_idle", int'(busy[0]), 0);
        enable = 1'b1;
        n = 0;
        while (!tick[0] && n < 400) begin
            step(1);
            n++;
        end
        // Counter sits at 0 on the enable cycle; tick is its TICK_DIV-th cycle.
        chk("en_first_tick", n, 199);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
